transpose_sequencer: RTL and testbench

Bus-slave/bus-master controller that feeds the 8x8 bit-matrix transpose peripheral without CPU polling. The CPU pushes matrix words into an 8-word input FIFO through the openMSP430 peripheral bus. The sequencer drives the transpose unit over a private peripheral-style bus: write 4 rows, start, poll done, read 4 results. Results land in an 8-word output FIFO for the CPU to drain.

---
 rtl/transpose_sequencer_if.sv | 19 +
 rtl/transpose_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_transpose_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_sequencer_if.sv
// Word-wide peripheral bus in openMSP430 style; per_din carries write data
// from the master, per_dout carries read data back from the slave.
interface transpose_sequencer_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/transpose_sequencer.sv
// CPU-fed sequencer for the 8x8 bit-matrix transpose unit: input FIFO -> 4 row
// writes, start, done poll, 4 result reads -> output FIFO.

module transpose_sequencer_fifo (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [3:0]  cnt
);
    logic [15:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Fullness is judged before a same-cycle pop, so a push into a full FIFO drops.
    assign do_push = push && (cnt != 4'd8);
    assign do_pop  = pop && (cnt != 4'd0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 3'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 3'd1;
            cnt <= cnt + 4'(do_push) - 4'(do_pop);
        end
    end
endmodule

module transpose_sequencer #(
    parameter logic [13:0] BASE_ADDR = 14'h090,
    parameter logic [13:0] TP_ADDR   = 14'h088,
    parameter int          POLL_MAX  = 16
) (
    input  logic                         mclk,
    input  logic                         puc_rst,
    transpose_sequencer_if.slave         cpu,
    transpose_sequencer_if.master        tp,
    output logic                         irq
);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_GO, S_POLL, S_RD} state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [PW-1:0] poll_cnt;
    logic [13:0]   m_addr;
    logic [15:0]   m_dout;
    logic          m_en;
    logic [1:0]    m_we;

    logic        en, ie, ovf, err, busy;
    logic        cpu_wr, cpu_rd, sel_ctrl, sel_din, sel_dout;
    logic        clr, start, push_in, pop_in, push_out, pop_out;
    logic        poll_done, poll_to;
    logic [15:0] in_head, out_head, ctrl_rd, rdata;
    logic [3:0]  in_cnt, out_cnt;

    assign cpu_wr   = cpu.per_en && (cpu.per_we == 2'b11);
    assign cpu_rd   = cpu.per_en && (cpu.per_we == 2'b00);
    assign sel_ctrl = (cpu.per_addr == BASE_ADDR);
    assign sel_din  = (cpu.per_addr == BASE_ADDR + 14'd1);
    assign sel_dout = (cpu.per_addr == BASE_ADDR + 14'd2);

    assign clr      = cpu_wr && sel_ctrl && cpu.per_din[1];
    assign push_in  = cpu_wr && sel_din;
    assign pop_out  = cpu_rd && sel_dout;
    assign busy     = (state != S_IDLE);

    // A job starts only when its four results are guaranteed room downstream.
    assign start    = (state == S_IDLE) && en && (in_cnt >= 4'd4) && (out_cnt <= 4'd4) && !clr;
    assign pop_in   = !clr && (start || ((state == S_WR) && (idx != 2'd3)));
    assign push_out = !clr && (state == S_RD);

    assign poll_done = (tp.per_dout == 16'h0100);
    assign poll_to   = (state == S_POLL) && !poll_done && (poll_cnt == PW'(POLL_MAX - 1));

    transpose_sequencer_fifo u_in_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .flush   (clr),
        .push    (push_in),
        .pop     (pop_in),
        .wdata   (cpu.per_din),
        .rdata   (in_head),
        .cnt     (in_cnt)
    );

    transpose_sequencer_fifo u_out_fifo (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .flush   (clr),
        .push    (push_out),
        .pop     (pop_out),
        .wdata   (tp.per_dout),
        .rdata   (out_head),
        .cnt     (out_cnt)
    );

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            en  <= 1'b0;
            ie  <= 1'b0;
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            if (cpu_wr && sel_ctrl) begin
                en <= cpu.per_din[0];
                ie <= cpu.per_din[3];
                if (cpu.per_din[2]) ovf <= 1'b0;
                if (cpu.per_din[5]) err <= 1'b0;
            end
            if (push_in && (in_cnt == 4'd8)) ovf <= 1'b1;
            if (poll_to && !clr) err <= 1'b1;
        end
    end

    assign ctrl_rd = {out_cnt, in_cnt, 2'b00, err, busy, ie, ovf, 1'b0, en};

    always_comb begin
        rdata = 16'h0000;
        if (cpu_rd && sel_ctrl)
            rdata = ctrl_rd;
        else if (cpu_rd && sel_dout && (out_cnt != 4'd0))
            rdata = out_head;
    end

    assign cpu.per_dout = rdata;
    assign irq          = ie && (out_cnt >= 4'd4);

    // Bus outputs are loaded with the values of the state being entered.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            poll_cnt <= '0;
            m_addr   <= '0;
            m_dout   <= '0;
            m_en     <= 1'b0;
            m_we     <= 2'b00;
        end else if (clr) begin
            state    <= S_IDLE;
            idx      <= '0;
            poll_cnt <= '0;
            m_addr   <= '0;
            m_dout   <= '0;
            m_en     <= 1'b0;
            m_we     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_WR;
                    idx    <= '0;
                    m_en   <= 1'b1;
                    m_we   <= 2'b11;
                    m_addr <= TP_ADDR + 14'd2;
                    m_dout <= in_head;
                end
                S_WR: if (idx == 2'd3) begin
                    state  <= S_GO;
                    m_addr <= TP_ADDR;
                    m_dout <= 16'h0001;
                end else begin
                    idx    <= idx + 2'd1;
                    m_addr <= TP_ADDR + 14'd3 + 14'(idx);
                    m_dout <= in_head;
                end
                S_GO: begin
                    state    <= S_POLL;
                    poll_cnt <= '0;
                    m_we     <= 2'b00;
                    m_addr   <= TP_ADDR;
                    m_dout   <= 16'h0000;
                end
                S_POLL: if (poll_done) begin
                    state  <= S_RD;
                    idx    <= '0;
                    m_addr <= TP_ADDR + 14'd2;
                end else if (poll_to) begin
                    state  <= S_IDLE;
                    m_en   <= 1'b0;
                    m_addr <= '0;
                end else begin
                    poll_cnt <= poll_cnt + PW'(1);
                end
                S_RD: if (idx == 2'd3) begin
                    state  <= S_IDLE;
                    idx    <= '0;
                    m_en   <= 1'b0;
                    m_addr <= '0;
                end else begin
                    idx    <= idx + 2'd1;
                    m_addr <= TP_ADDR + 14'd3 + 14'(idx);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tp.per_addr = m_addr;
    assign tp.per_din  = m_dout;
    assign tp.per_en   = m_en;
    assign tp.per_we   = m_we;
endmodule

// File: tb/tb_transpose_sequencer.sv
// Directed + randomized bench for transpose_sequencer with a behavioural
// transpose peripheral and a queue-based model of the sequencer.
module tb_transpose_sequencer;
    localparam logic [13:0] BASE = 14'h090;
    localparam logic [13:0] TP   = 14'h088;
    localparam logic [13:0] CTRL = BASE;
    localparam logic [13:0] DIN  = BASE + 14'd1;
    localparam logic [13:0] DOUT = BASE + 14'd2;

    logic mclk = 1'b0;
    logic puc_rst = 1'b1;
    logic irq;
    always #5 mclk = ~mclk;

    transpose_sequencer_if cpu ();
    transpose_sequencer_if tp ();

    transpose_sequencer #(.BASE_ADDR(BASE), .TP_ADDR(TP), .POLL_MAX(16)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .cpu     (cpu),
        .tp      (tp),
        .irq     (irq)
    );

    // Bit row*8+col of the 64-bit matrix {w3,w2,w1,w0} is row/col of the spec.
    function automatic logic [63:0] tpose(input logic [63:0] m);
        logic [63:0] t;
        t = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[c*8+r] = m[r*8+c];
        return t;
    endfunction

    // Behavioural transpose peripheral
    logic [15:0] tp_mat [4] = '{default: 16'h0000};
    logic        tp_started = 1'b0;
    int          tp_polls = 0, poll_reads = 0, rd_reads = 0, bus_cycles = 0;
    bit          never_done = 1'b0;
    logic [63:0] tp_t;
    logic [15:0] tp_rdata;
    logic        tp_in_mat;

    assign tp_t      = tpose({tp_mat[3], tp_mat[2], tp_mat[1], tp_mat[0]});
    assign tp_in_mat = (tp.per_addr >= TP + 14'd2) && (tp.per_addr <= TP + 14'd5);
    assign tp.per_dout = tp_rdata;

    always_comb begin
        tp_rdata = 16'h0000;
        if (tp.per_en && tp.per_we == 2'b00) begin
            if (tp.per_addr == TP)
                tp_rdata = (tp_started && !never_done && tp_polls >= 1) ? 16'h0100 : 16'h0000;
            else if (tp_in_mat)
                tp_rdata = tp_t[16*int'(tp.per_addr - TP - 14'd2) +: 16];
        end
    end

    always @(posedge mclk) begin
        if (tp.per_en) begin
            bus_cycles <= bus_cycles + 1;
            if (tp.per_we == 2'b11) begin
                if (tp.per_addr == TP && tp.per_din == 16'h0001) begin
                    tp_started <= 1'b1;
                    tp_polls   <= 0;
                end else if (tp_in_mat) begin
                    tp_mat[2'(tp.per_addr - TP - 14'd2)] <= tp.per_din;
                end
            end else if (tp.per_we == 2'b00) begin
                if (tp.per_addr == TP) begin
                    poll_reads <= poll_reads + 1;
                    tp_polls   <= tp_polls + 1;
                end else if (tp_in_mat) begin
                    rd_reads <= rd_reads + 1;
                end
            end
        end
    end

    // Reference model of the sequencer
    logic [15:0] in_q[$];
    logic [15:0] out_q[$];
    bit m_en = 0, m_ie = 0, m_ovf = 0, m_err = 0;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ctrl();
        return {4'(out_q.size()), 4'(in_q.size()), 2'b00, m_err, 1'b0, m_ie, m_ovf, 1'b0, m_en};
    endfunction

    task automatic model_jobs();
        logic [63:0] m, t;
        while (m_en && in_q.size() >= 4 && out_q.size() <= 4) begin
            for (int k = 0; k < 4; k++) m[16*k +: 16] = in_q.pop_front();
            t = tpose(m);
            for (int k = 0; k < 4; k++) out_q.push_back(t[16*k +: 16]);
        end
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        @(negedge mclk);
        cpu.per_addr = a;
        cpu.per_din  = d;
        cpu.per_we   = we;
        cpu.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        cpu.per_en = 1'b0;
        cpu.per_we = 2'b00;
    endtask

    task automatic cpu_read(input logic [13:0] a, output logic [15:0] d);
        @(negedge mclk);
        cpu.per_addr = a;
        cpu.per_we   = 2'b00;
        cpu.per_en   = 1'b1;
        #1 d = cpu.per_dout;
        @(posedge mclk);
        #1;
        cpu.per_en = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        cpu_write(DIN, w, 2'b11);
        if (in_q.size() < 8) in_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic set_ctrl(input logic [15:0] v);
        cpu_write(CTRL, v, 2'b11);
        m_en = v[0];
        m_ie = v[3];
        if (v[2]) m_ovf = 1'b0;
        if (v[5]) m_err = 1'b0;
        if (v[1]) begin
            in_q.delete();
            out_q.delete();
        end
    endtask

    task automatic pop_check(input string tag, output logic [15:0] d);
        logic [15:0] e;
        cpu_read(DOUT, d);
        e = (out_q.size() > 0) ? out_q.pop_front() : 16'h0000;
        check(tag, d, e);
    endtask

    task automatic check_ctrl(input string tag);
        logic [15:0] c;
        cpu_read(CTRL, c);
        check(tag, c, exp_ctrl());
    endtask

    task automatic wait_ctrl(input string tag, input logic [15:0] mask, input logic [15:0] val,
                             input int limit, output int cyc);
        logic [15:0] c;
        c = '0;
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            cpu_read(CTRL, c);
            if ((c & mask) == val) begin
                cyc = i;
                break;
            end
        end
        check(tag, c & mask, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, w;
        logic [15:0] ident [4];
        int cyc, p0, r0, b0, n;
        bit found;

        ident = '{16'h0201, 16'h0804, 16'h2010, 16'h8040};
        cpu.per_addr = '0;
        cpu.per_din  = '0;
        cpu.per_we   = 2'b00;
        cpu.per_en   = 1'b0;
        repeat (3) @(negedge mclk);
        puc_rst = 1'b0;
        #1;
        check("rst_m_en", 16'(tp.per_en), 16'd0);
        check("rst_m_we", 16'(tp.per_we), 16'd0);
        check("rst_m_addr", 16'(tp.per_addr), 16'd0);
        check("rst_m_dout", tp.per_din, 16'd0);
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_per_dout_idle", cpu.per_dout, 16'd0);
        check_ctrl("rst_ctrl");
        cpu_write(CTRL, 16'h0009, 2'b01);
        check_ctrl("byte_write_ignored");

        // Identity matrix and nominal latency
        set_ctrl(16'h0001);
        for (int k = 0; k < 4; k++) push(ident[k]);
        wait_ctrl("ident_out4", 16'hF000, 16'h4000, 14, cyc);
        check("ident_latency", 16'(cyc), 16'd12);
        model_jobs();
        for (int k = 0; k < 4; k++) begin
            pop_check("ident_model", d);
            check("ident_const", d, ident[k]);
        end
        check_ctrl("ident_idle");

        // Row 0 all ones
        push(16'h00FF); push(16'h0000); push(16'h0000); push(16'h0000);
        wait_ctrl("row0_out4", 16'hF000, 16'h4000, 20, cyc);
        model_jobs();
        for (int k = 0; k < 4; k++) begin
            pop_check("row0_model", d);
            check("row0_const", d, 16'h0101);
        end

        // Random matrices, one or two jobs at a time
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 2);
            for (int k = 0; k < 4 * n; k++) push(16'($urandom));
            wait_ctrl("rand_out", 16'hF000, 16'(4 * n) << 12, 60, cyc);
            model_jobs();
            for (int k = 0; k < 4 * n; k++) pop_check("rand_data", d);
            check_ctrl("rand_ctrl");
        end

        // Overflow, back-to-back jobs, irq and output reservation
        set_ctrl(16'h0000);
        for (int k = 0; k < 9; k++) push(16'($urandom));
        check_ctrl("ovf_set");
        set_ctrl(16'h0004);
        check_ctrl("ovf_w1c");
        set_ctrl(16'h0009);
        wait_ctrl("b2b_out8", 16'hF000, 16'h8000, 60, cyc);
        model_jobs();
        check("b2b_irq", 16'(irq), 16'd1);
        check_ctrl("b2b_ctrl");
        pop_check("resv_pop", d);
        pop_check("resv_pop", d);
        for (int k = 0; k < 4; k++) push(16'($urandom));
        repeat (20) @(negedge mclk);
        model_jobs();
        check_ctrl("resv_hold");
        check("resv_irq", 16'(irq), 16'd1);
        pop_check("resv_pop", d);
        pop_check("resv_pop", d);
        wait_ctrl("resv_out8", 16'hF000, 16'h8000, 40, cyc);
        model_jobs();
        for (int k = 0; k < 8; k++) pop_check("resv_drain", d);
        check("drain_irq", 16'(irq), 16'd0);
        pop_check("empty_dout", d);
        check_ctrl("empty_ctrl");
        set_ctrl(16'h0001);

        // Poll timeout
        never_done = 1'b1;
        p0 = poll_reads;
        r0 = rd_reads;
        for (int k = 0; k < 4; k++) push(16'($urandom));
        wait_ctrl("to_err", 16'h0020, 16'h0020, 60, cyc);
        for (int k = 0; k < 4; k++) void'(in_q.pop_front());
        m_err = 1'b1;
        check("to_polls", 16'(poll_reads - p0), 16'd16);
        check("to_rds", 16'(rd_reads - r0), 16'd0);
        check_ctrl("to_ctrl");
        set_ctrl(16'h0021);
        check_ctrl("err_w1c");

        // CLR during POLL with both FIFOs holding data
        never_done = 1'b0;
        for (int k = 0; k < 4; k++) push(16'($urandom));
        wait_ctrl("clr_prep", 16'hF000, 16'h4000, 20, cyc);
        model_jobs();
        never_done = 1'b1;
        for (int k = 0; k < 8; k++) push(16'($urandom));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge mclk);
            #1;
            if (tp.per_en && tp.per_we == 2'b00 && tp.per_addr == TP) found = 1'b1;
        end
        check("clr_poll_seen", 16'(found), 16'd1);
        set_ctrl(16'h0003);
        check("clr_m_en", 16'(tp.per_en), 16'd0);
        b0 = bus_cycles;
        repeat (10) @(negedge mclk);
        check("clr_no_bus", 16'(bus_cycles - b0), 16'd0);
        check_ctrl("clr_ctrl");

        // Reset asserted during WR2
        never_done = 1'b0;
        set_ctrl(16'h0009);
        for (int k = 0; k < 4; k++) push(16'($urandom));
        wait_ctrl("rst_prep", 16'hF000, 16'h4000, 20, cyc);
        model_jobs();
        for (int k = 0; k < 4; k++) push(16'hA5A5);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge mclk);
            #1;
            if (tp.per_en && tp.per_we == 2'b11 && tp.per_addr == TP + 14'd4) found = 1'b1;
        end
        check("wr2_seen", 16'(found), 16'd1);
        check("wr2_irq_before", 16'(irq), 16'd1);
        #2 puc_rst = 1'b1;
        cpu.per_addr = CTRL;
        cpu.per_we   = 2'b00;
        cpu.per_en   = 1'b1;
        #1;
        check("arst_m_en", 16'(tp.per_en), 16'd0);
        check("arst_m_we", 16'(tp.per_we), 16'd0);
        check("arst_m_addr", 16'(tp.per_addr), 16'd0);
        check("arst_m_dout", tp.per_din, 16'd0);
        check("arst_irq", 16'(irq), 16'd0);
        check("arst_ctrl_rd", cpu.per_dout, 16'd0);
        @(negedge mclk);
        cpu.per_en = 1'b0;
        puc_rst = 1'b0;
        in_q.delete();
        out_q.delete();
        m_en = 0; m_ie = 0; m_ovf = 0; m_err = 0;
        check_ctrl("post_rst_ctrl");

        w = 16'h0000;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
